// File: rtl/mux_rr_pipe_if.sv
// Handshake bundle for mux_rr_pipe: N input channels plus one output channel.
// master = upstream/downstream environment, slave = the selector itself.
interface mux_rr_pipe_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_src;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/mux_rr_pipe.sv
// N-way registered selector with valid/ready on every channel; external select or round-robin.
// Optional macro MUX_STALL_CNT_EN adds a saturating stall_cnt output.
module mux_rr_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic          clk,
    input  logic          rst,
    mux_rr_pipe_if.slave  bus
`ifdef MUX_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);
    localparam logic [SELW-1:0] PTR_RST = SELW'(N - 1);
    localparam logic [SELW:0]   N_L     = (SELW + 1)'(N);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             can_load_s;
    logic             grant_vld_s;
    logic [SELW-1:0]  grant_idx_s;
    logic [N-1:0]     in_ready_s;
    logic             xfer_s;

    assign can_load_s = !out_valid_q || bus.out_ready;

    generate
        if (MODE == 0) begin : g_ext
            // Select values past N-1 (non-power-of-two N) never grant.
            always_comb begin
                grant_vld_s = ({1'b0, bus.sel} < N_L);
                grant_idx_s = bus.sel;
            end
        end else begin : g_rr
            // Search starts one past the last served channel and wraps at N.
            always_comb begin
                logic [SELW:0]   idx_s;
                logic [SELW-1:0] idx_w_s;
                logic            hit_s;
                grant_vld_s = 1'b0;
                grant_idx_s = rr_ptr_q;
                idx_s       = '0;
                idx_w_s     = '0;
                hit_s       = 1'b0;
                for (int i = 1; i <= N; i++) begin
                    idx_s       = {1'b0, rr_ptr_q} + (SELW + 1)'(i);
                    idx_s       = (idx_s >= N_L) ? (idx_s - N_L) : idx_s;
                    idx_w_s     = idx_s[SELW-1:0];
                    hit_s       = !grant_vld_s && bus.in_valid[idx_w_s];
                    grant_idx_s = hit_s ? idx_w_s : grant_idx_s;
                    grant_vld_s = grant_vld_s | hit_s;
                end
            end
        end
    endgenerate

    // Only the granted channel may see ready; reset withdraws it so nothing is lost.
    always_comb begin
        in_ready_s = '0;
        if (grant_vld_s && can_load_s && !rst) begin
            in_ready_s[grant_idx_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    assign xfer_s       = grant_vld_s && can_load_s && !rst && bus.in_valid[grant_idx_s];
    assign bus.in_ready = in_ready_s;

    // Output register next state: load on transfer, drain when free, hold on stall.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer_s) begin
            out_data_d  = bus.in_data[grant_idx_s*WIDTH +: WIDTH];
            out_src_d   = grant_idx_s;
            out_valid_d = 1'b1;
            rr_ptr_d    = grant_idx_s;
        end else if (can_load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output stage and round-robin pointer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= PTR_RST;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;

`ifdef MUX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles the output word is held by backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'h0000_0000;
        end else if (out_valid_q && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'h0000_0001;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule
